// File: rtl/wb_sram_flash_ctrl.sv
// Wishbone slave for the shared SRAM/flash pads.
// Handles byte/word access with per-device wait states.
// Unaligned words are split into two byte phases.
// Flash is write-protected: writes to it are acked and discarded.
module wb_sram_flash_ctrl #(
    parameter int unsigned SRAM_WAIT  = 2,
    parameter int unsigned FLASH_WAIT = 3,
    parameter logic [3:0]  ROM_SEG_A  = 4'hC,
    parameter logic [3:0]  ROM_SEG_B  = 4'hF,
    parameter bit          SIGN_EXT   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [19:0] adr_i,
    input  logic [15:0] dat_i,
    output logic [15:0] dat_o,
    input  logic        we_i,
    input  logic        byte_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    output logic        ack_o,
    output logic        sram_clk_,
    output logic [20:0] sram_flash_addr_,
    inout  wire  [15:0] sram_flash_data_,
    output logic        sram_flash_oe_n_,
    output logic        sram_flash_we_n_,
    output logic [3:0]  sram_bw_,
    output logic        sram_cen_,
    output logic        flash_ce2_
);

    typedef enum logic [1:0] {IDLE, PH1, PH2, ACK} state_t;

    state_t      state_q, state_d;
    logic [19:0] adr_q;
    logic [15:0] dat_q;
    logic        we_q, byte_q, split_q;
    logic [3:0]  cnt_q;
    logic [7:0]  lo_q;

    logic [19:0] ph_adr;
    logic        ph_rom, ph_byte, in_phase, last;
    logic [7:0]  ph_wbyte, rd_lane;
    logic [15:0] wdata;
    logic        drive;

    function automatic logic is_rom(input logic [19:0] a);
        return (a[19:16] == ROM_SEG_A) || (a[19:16] == ROM_SEG_B);
    endfunction

    function automatic logic [3:0] wait_for(input logic [19:0] a);
        return is_rom(a) ? 4'(FLASH_WAIT) : 4'(SRAM_WAIT);
    endfunction

    function automatic logic [15:0] ext(input logic [7:0] b);
        return SIGN_EXT ? {{8{b[7]}}, b} : {8'h00, b};
    endfunction

    assign sram_clk_       = clk_i;
    assign ack_o           = (state_q == ACK);
    assign sram_flash_data_ = drive ? wdata : 16'hzzzz;

    // Phase decode, pad outputs and next-state selection.
    always_comb begin
        in_phase = (state_q == PH1) || (state_q == PH2);
        ph_adr   = (state_q == PH2) ? adr_q + 20'd1 : adr_q;
        ph_rom   = is_rom(ph_adr);
        ph_byte  = byte_q | split_q;
        last     = (cnt_q == 4'd0);
        ph_wbyte = (state_q == PH2) ? dat_q[15:8] : dat_q[7:0];
        wdata    = ph_byte ? {ph_wbyte, ph_wbyte} : dat_q;
        rd_lane  = ph_adr[0] ? sram_flash_data_[15:8] : sram_flash_data_[7:0];
        sram_flash_addr_ = ph_rom ? {5'b0, ph_adr[17], ph_adr[15:1]}
                                  : {2'b0, ph_adr[19:16], ph_adr[15:1]};

        sram_flash_oe_n_ = 1'b1;
        sram_flash_we_n_ = 1'b1;
        sram_cen_        = 1'b1;
        flash_ce2_       = 1'b0;
        sram_bw_         = 4'hF;
        drive            = 1'b0;
        state_d          = state_q;

        if (in_phase) begin
            if (ph_rom) flash_ce2_ = 1'b1;
            else        sram_cen_  = 1'b0;
            if (!we_q) begin
                sram_flash_oe_n_ = 1'b0;
            end else if (!ph_rom) begin
                drive            = 1'b1;
                sram_flash_we_n_ = last;
                sram_bw_         = ph_byte ? (ph_adr[0] ? 4'b1101 : 4'b1110) : 4'b1100;
            end
        end

        case (state_q)
            IDLE: if (cyc_i && stb_i) state_d = (we_i && is_rom(adr_i)) ? ACK : PH1;
            PH1: begin
                if (!cyc_i)    state_d = IDLE;
                else if (last) state_d = split_q ? PH2 : ACK;
            end
            PH2: begin
                if (!cyc_i)    state_d = IDLE;
                else if (last) state_d = ACK;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, request latch, wait counter and read capture.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            split_q <= 1'b0;
            cnt_q   <= '0;
            lo_q    <= '0;
            dat_o   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (cyc_i && stb_i) begin
                    adr_q   <= adr_i;
                    dat_q   <= dat_i;
                    we_q    <= we_i;
                    byte_q  <= byte_i;
                    split_q <= !byte_i && adr_i[0];
                    cnt_q   <= wait_for(adr_i);
                    if (we_i && is_rom(adr_i)) dat_o <= '0;
                end
                PH1, PH2: if (cyc_i) begin
                    if (!last) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        // The second phase may land in a different region.
                        if (state_q == PH1 && split_q) cnt_q <= wait_for(adr_q + 20'd1);
                        if (!we_q) begin
                            if (state_q == PH2)  dat_o <= {rd_lane, lo_q};
                            else if (split_q)    lo_q  <= rd_lane;
                            else if (byte_q)     dat_o <= ext(rd_lane);
                            else                 dat_o <= sram_flash_data_;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram_flash_ctrl.sv
// Directed bench for wb_sram_flash_ctrl; a second instance uses zero extension.
module tb_wb_sram_flash_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i, we_i, byte_i, cyc_i, stb_i;
    logic [19:0] adr_i;
    logic [15:0] dat_i;

    logic [15:0] dat_o, dat_o2;
    logic        ack_o, ack_o2, sclk, sclk2;
    logic [20:0] addr, addr2;
    logic        oe_n, we_n, cen, ce2, oe_n2, we_n2, cen2, ce22;
    logic [3:0]  bw, bw2;
    wire  [15:0] pad, pad2;

    logic [15:0] rd_val, rd_val2;
    logic [20:0] rd_addr2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    // Pad model: responds only while the controller enables its outputs.
    assign pad  = !oe_n  ? ((addr  == rd_addr2) ? rd_val2 : rd_val) : 16'hzzzz;
    assign pad2 = !oe_n2 ? ((addr2 == rd_addr2) ? rd_val2 : rd_val) : 16'hzzzz;

    wb_sram_flash_ctrl #(.SRAM_WAIT(2), .FLASH_WAIT(3), .ROM_SEG_A(4'hC),
                         .ROM_SEG_B(4'hF), .SIGN_EXT(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .we_i(we_i), .byte_i(byte_i), .cyc_i(cyc_i), .stb_i(stb_i), .ack_o(ack_o),
        .sram_clk_(sclk), .sram_flash_addr_(addr), .sram_flash_data_(pad),
        .sram_flash_oe_n_(oe_n), .sram_flash_we_n_(we_n), .sram_bw_(bw),
        .sram_cen_(cen), .flash_ce2_(ce2));

    wb_sram_flash_ctrl #(.SRAM_WAIT(2), .FLASH_WAIT(3), .ROM_SEG_A(4'hC),
                         .ROM_SEG_B(4'hF), .SIGN_EXT(1'b0)) dut_zx (
        .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o2),
        .we_i(we_i), .byte_i(byte_i), .cyc_i(cyc_i), .stb_i(stb_i), .ack_o(ack_o2),
        .sram_clk_(sclk2), .sram_flash_addr_(addr2), .sram_flash_data_(pad2),
        .sram_flash_oe_n_(oe_n2), .sram_flash_we_n_(we_n2), .sram_bw_(bw2),
        .sram_cen_(cen2), .flash_ce2_(ce22));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    // Present a request in cycle 0; returns in cycle 1 with stb_i dropped.
    task automatic go(input logic [19:0] a, input logic [15:0] d, input logic w, input logic b);
        adr_i = a; dat_i = d; we_i = w; byte_i = b; cyc_i = 1'b1; stb_i = 1'b1;
        step();
        stb_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; byte_i = 1'b0;
        adr_i = '0; dat_i = '0;
        rd_val = 16'h0000; rd_val2 = 16'h0000; rd_addr2 = 21'h1FFFFF;
        #1;
        steps(2);
        chk("rst_ack",  ack_o, 0);
        chk("rst_dat",  dat_o, 0);
        chk("rst_oe",   oe_n, 1);
        chk("rst_we",   we_n, 1);
        chk("rst_cen",  cen, 1);
        chk("rst_ce2",  ce2, 0);
        chk("rst_bw",   bw, 4'hF);
        rst_i = 1'b1;
        step();

        // SRAM word read at 0x12344
        rd_val = 16'hBEEF;
        go(20'h12344, 16'h0000, 1'b0, 1'b0);
        chk("wr_oe_c1",   oe_n, 0);
        chk("wr_cen_c1",  cen, 0);
        chk("wr_addr",    addr, 21'h0091A2);
        steps(2);
        chk("wr_oe_c3",   oe_n, 0);
        chk("wr_ack_c3",  ack_o, 0);
        step();
        chk("wr_ack_c4",  ack_o, 1);
        chk("wr_dat",     dat_o, 16'hBEEF);
        chk("wr_oe_c4",   oe_n, 1);
        step();
        chk("wr_ack_c5",  ack_o, 0);
        cyc_i = 1'b0;

        // SRAM odd byte write 0xA5 at 0x00003
        go(20'h00003, 16'h00A5, 1'b1, 1'b1);
        chk("bw_bw",      bw, 4'b1101);
        chk("bw_lane1",   pad[15:8], 8'hA5);
        chk("bw_we_c1",   we_n, 0);
        chk("bw_oe_c1",   oe_n, 1);
        chk("bw_addr",    addr, 21'h000001);
        step();
        chk("bw_we_c2",   we_n, 0);
        step();
        chk("bw_we_c3",   we_n, 1);
        chk("bw_hold_c3", pad[15:8], 8'hA5);
        chk("bw_ack_c3",  ack_o, 0);
        step();
        chk("bw_ack_c4",  ack_o, 1);
        step();
        cyc_i = 1'b0;

        // Split word write 0x1234 at 0x0FFFF
        go(20'h0FFFF, 16'h1234, 1'b1, 1'b0);
        chk("sw_addr1",   addr, 21'h007FFF);
        chk("sw_bw1",     bw, 4'b1101);
        chk("sw_lane1",   pad[15:8], 8'h34);
        steps(3);
        chk("sw_addr2",   addr, 21'h008000);
        chk("sw_bw2",     bw, 4'b1110);
        chk("sw_lane0",   pad[7:0], 8'h12);
        chk("sw_we_c4",   we_n, 0);
        steps(2);
        chk("sw_we_c6",   we_n, 1);
        chk("sw_ack_c6",  ack_o, 0);
        step();
        chk("sw_ack_c7",  ack_o, 1);
        step();
        cyc_i = 1'b0;

        // Flash odd byte read at 0xF0001, sign vs zero extension
        rd_val = 16'h8011;
        go(20'hF0001, 16'h0000, 1'b0, 1'b1);
        chk("fr_ce2",     ce2, 1);
        chk("fr_cen",     cen, 1);
        chk("fr_oe",      oe_n, 0);
        chk("fr_addr",    addr, 21'h008000);
        steps(3);
        chk("fr_ack_c4",  ack_o, 0);
        step();
        chk("fr_ack_c5",  ack_o, 1);
        chk("fr_dat_sx",  dat_o, 16'hFF80);
        chk("fr_ack_zx",  ack_o2, 1);
        chk("fr_dat_zx",  dat_o2, 16'h0080);
        step();
        cyc_i = 1'b0;

        // SRAM even byte read at 0x00002
        rd_val = 16'h1290;
        go(20'h00002, 16'h0000, 1'b0, 1'b1);
        steps(3);
        chk("er_ack_c4",  ack_o, 1);
        chk("er_dat_sx",  dat_o, 16'hFF90);
        chk("er_dat_zx",  dat_o2, 16'h0090);
        step();
        cyc_i = 1'b0;

        // Write to protected flash area
        go(20'hC0000, 16'h5555, 1'b1, 1'b0);
        chk("fw_ack_c1",  ack_o, 1);
        chk("fw_we",      we_n, 1);
        chk("fw_ce2",     ce2, 0);
        chk("fw_dat",     dat_o, 16'h0000);
        step();
        chk("fw_ack_c2",  ack_o, 0);
        cyc_i = 1'b0;

        // Split word read crossing flash 0xFFFFF -> SRAM 0x00000
        rd_val = 16'h7F11; rd_addr2 = 21'h000000; rd_val2 = 16'h22C3;
        go(20'hFFFFF, 16'h0000, 1'b0, 1'b0);
        chk("sr_addr1",   addr, 21'h00FFFF);
        chk("sr_ce2_c1",  ce2, 1);
        steps(3);
        chk("sr_ce2_c4",  ce2, 1);
        chk("sr_oe_c4",   oe_n, 0);
        step();
        chk("sr_cen_c5",  cen, 0);
        chk("sr_ce2_c5",  ce2, 0);
        chk("sr_addr2",   addr, 21'h000000);
        steps(2);
        chk("sr_ack_c7",  ack_o, 0);
        step();
        chk("sr_ack_c8",  ack_o, 1);
        chk("sr_dat",     dat_o, 16'hC37F);
        chk("sr_dat_zx",  dat_o2, 16'hC37F);
        step();
        cyc_i = 1'b0;
        rd_addr2 = 21'h1FFFFF;

        // Abort in the second cycle of PH1
        go(20'h00010, 16'h0000, 1'b0, 1'b0);
        chk("ab_oe_c1",   oe_n, 0);
        step();
        chk("ab_oe_c2",   oe_n, 0);
        cyc_i = 1'b0;
        step();
        chk("ab_oe_c3",   oe_n, 1);
        chk("ab_cen_c3",  cen, 1);
        chk("ab_ack_c3",  ack_o, 0);
        steps(3);
        chk("ab_ack_c6",  ack_o, 0);
        chk("ab_dat",     dat_o, 16'hC37F);

        // Reset during PH2 of a split read
        go(20'h00001, 16'h0000, 1'b0, 1'b0);
        chk("rs_addr1",   addr, 21'h000000);
        steps(3);
        chk("rs_addr2",   addr, 21'h000001);
        step();
        chk("rs_oe_c5",   oe_n, 0);
        rst_i = 1'b0;
        step();
        chk("rs_ack",     ack_o, 0);
        chk("rs_oe",      oe_n, 1);
        chk("rs_cen",     cen, 1);
        chk("rs_we",      we_n, 1);
        chk("rs_bw",      bw, 4'hF);
        chk("rs_dat",     dat_o, 16'h0000);
        rst_i = 1'b1;
        cyc_i = 1'b0;
        steps(3);
        chk("rs_ack_after", ack_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
